// File: rtl/parser_pkg.sv
// Shared parser/deparser types: the type-lookup rule layout and its config-bus constants.
// No logic, so no latency.
// No handshakes here; the rule sequencer owns flow control.
package parser_pkg;

  localparam int RULE_NUM    = 6;
  localparam int CFG_DW      = 32;
  localparam int CFG_WORD_AW = 4;

  // One type-lookup rule. The valid flag is the MSB so a commit can override it cheaply.
  typedef struct packed {
    logic        typeRule_valid;
    logic [15:0] typeRule_keyValue;
    logic [15:0] typeRule_keyMask;
    logic [7:0]  typeRule_headType;
    logic [7:0]  typeRule_headLen;
    logic [7:0]  typeRule_nextState;
    logic [12:0] typeRule_offset;
  } type_rule_t;

  localparam int TYPE_RULE_BITS  = $bits(type_rule_t);
  localparam int RULE_WORDS      = (TYPE_RULE_BITS + CFG_DW - 1) / CFG_DW;
  localparam int CFG_WORD_COMMIT = (1 << CFG_WORD_AW) - 1;
  localparam int CFG_WORD_CLEAR  = (1 << CFG_WORD_AW) - 2;

  typedef enum logic [1:0] {
    IDLE,
    COMMIT,
    CLEAR
  } cfg_state_e;

endpackage

// File: rtl/type_rule_cfg.sv
// Assembles host config words into a shadow rule; commits it to one slot or clears all slots.
// Shadow load 1 cycle; commit pulses wren the cycle after accept; clear-all spans RULE_NUM cycles.
// o_cfg_ready drops for the whole commit/clear sequence; a pending write is held, never dropped.
module type_rule_cfg
  import parser_pkg::*;
#(
  parameter int RULE_NUM = parser_pkg::RULE_NUM,
  parameter int RULE_AW  = (RULE_NUM > 1) ? $clog2(RULE_NUM) : 1,
  parameter int WORD_AW  = parser_pkg::CFG_WORD_AW,
  parameter int CFG_DW   = parser_pkg::CFG_DW
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_cfg_valid,
  output logic                       o_cfg_ready,
  input  logic [RULE_AW+WORD_AW-1:0] i_cfg_addr,
  input  logic [CFG_DW-1:0]          i_cfg_data,
  output logic [RULE_NUM-1:0]        o_rule_wren,
  output type_rule_t                 o_type_rule,
  output logic                       o_busy,
  output logic                       o_err
);

  localparam int N_WORDS = (TYPE_RULE_BITS + CFG_DW - 1) / CFG_DW;

  localparam logic [WORD_AW:0]   WORDS_W     = (WORD_AW+1)'(N_WORDS);
  localparam logic [RULE_AW:0]   RULE_NUM_W  = (RULE_AW+1)'(RULE_NUM);
  localparam logic [WORD_AW-1:0] WORD_COMMIT = WORD_AW'((1 << WORD_AW) - 1);
  localparam logic [WORD_AW-1:0] WORD_CLEAR  = WORD_AW'((1 << WORD_AW) - 2);
  localparam logic [RULE_AW-1:0] CLR_LAST    = RULE_AW'(RULE_NUM - 1);

  function automatic logic [RULE_NUM-1:0] onehot(input logic [RULE_AW-1:0] idx);
    logic [RULE_NUM-1:0] v;
    v = '0;
    for (int i = 0; i < RULE_NUM; i++) begin
      if (idx == RULE_AW'(i)) v[i] = 1'b1;
    end
    return v;
  endfunction

  cfg_state_e                state_q, state_nxt;
  logic [TYPE_RULE_BITS-1:0] shadow_q, shadow_nxt;
  logic [RULE_AW-1:0]        rule_q;
  logic [RULE_AW-1:0]        clr_cnt_q;
  type_rule_t                commit_rule;

  logic [WORD_AW-1:0] word_idx;
  logic [RULE_AW-1:0] rule_idx;
  logic               cfg_ready;
  logic [RULE_NUM-1:0] rule_wren;
  logic               load_word, do_commit, do_clear, bad_wr;

  assign word_idx    = i_cfg_addr[WORD_AW-1:0];
  assign rule_idx    = i_cfg_addr[RULE_AW+WORD_AW-1:WORD_AW];
  assign o_cfg_ready = cfg_ready;
  assign o_rule_wren = rule_wren;

  // Merge the incoming word into the shadow; bits past the rule width are dropped.
  always_comb begin
    shadow_nxt = shadow_q;
    for (int b = 0; b < TYPE_RULE_BITS; b++) begin
      if (int'(word_idx) == b / CFG_DW) shadow_nxt[b] = i_cfg_data[b % CFG_DW];
    end
  end

  // Rule presented on commit: the shadow with its valid flag taken from the command data.
  always_comb begin
    commit_rule                = type_rule_t'(shadow_q);
    commit_rule.typeRule_valid = i_cfg_data[0];
  end

  // Next-state and handshake/enable decode.
  always_comb begin
    state_nxt = state_q;
    cfg_ready = 1'b0;
    rule_wren = '0;
    load_word = 1'b0;
    do_commit = 1'b0;
    do_clear  = 1'b0;
    bad_wr    = 1'b0;
    case (state_q)
      IDLE: begin
        cfg_ready = 1'b1;
        if (i_cfg_valid) begin
          if ({1'b0, word_idx} < WORDS_W) begin
            load_word = 1'b1;
          end else if (word_idx == WORD_COMMIT && {1'b0, rule_idx} < RULE_NUM_W) begin
            do_commit = 1'b1;
            state_nxt = COMMIT;
          end else if (word_idx == WORD_CLEAR) begin
            do_clear  = 1'b1;
            state_nxt = CLEAR;
          end else begin
            bad_wr = 1'b1;
          end
        end
      end
      COMMIT: begin
        rule_wren = onehot(rule_q);
        state_nxt = IDLE;
      end
      CLEAR: begin
        rule_wren = onehot(clr_cnt_q);
        if (clr_cnt_q == CLR_LAST) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, shadow, presented rule and status registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      shadow_q    <= '0;
      rule_q      <= '0;
      clr_cnt_q   <= '0;
      o_type_rule <= '0;
      o_busy      <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      state_q <= state_nxt;
      o_busy  <= (state_nxt != IDLE);
      o_err   <= bad_wr;
      if (load_word) shadow_q <= shadow_nxt;
      if (do_commit) begin
        rule_q      <= rule_idx;
        o_type_rule <= commit_rule;
      end
      if (do_clear) begin
        o_type_rule <= '0;
        clr_cnt_q   <= '0;
      end else if (state_q == CLEAR) begin
        clr_cnt_q <= clr_cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_type_rule_cfg.sv
// Randomized and directed bench for type_rule_cfg against a word-level reference model.
// Checks each cycle after an accepted write for wren/ready/busy/err/rule.
// Exercises held-valid backpressure during clear and mid-clear reset.
module tb_type_rule_cfg;
  import parser_pkg::*;

  localparam int RN  = RULE_NUM;
  localparam int RAW = (RN > 1) ? $clog2(RN) : 1;
  localparam int WAW = CFG_WORD_AW;
  localparam int AW  = RAW + WAW;

  logic              i_clk = 1'b0;
  logic              i_rst_n = 1'b0;
  logic              i_cfg_valid = 1'b0;
  logic              o_cfg_ready;
  logic [AW-1:0]     i_cfg_addr = '0;
  logic [CFG_DW-1:0] i_cfg_data = '0;
  logic [RN-1:0]     o_rule_wren;
  type_rule_t        o_type_rule;
  logic              o_busy;
  logic              o_err;

  type_rule_cfg dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_cfg_valid (i_cfg_valid),
    .o_cfg_ready (o_cfg_ready),
    .i_cfg_addr  (i_cfg_addr),
    .i_cfg_data  (i_cfg_data),
    .o_rule_wren (o_rule_wren),
    .o_type_rule (o_type_rule),
    .o_busy      (o_busy),
    .o_err       (o_err)
  );

  always #5 i_clk = ~i_clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: the shadow as a flat array of config words, and the last presented rule.
  logic [CFG_DW-1:0] m_words [RULE_WORDS];
  type_rule_t        m_rule;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic type_rule_t model_commit(input logic v);
    logic [RULE_WORDS*CFG_DW-1:0] flat;
    type_rule_t t;
    for (int w = 0; w < RULE_WORDS; w++) flat[w*CFG_DW +: CFG_DW] = m_words[w];
    t = flat[TYPE_RULE_BITS-1:0];
    t.typeRule_valid = v;
    return t;
  endfunction

  function automatic logic [AW-1:0] mk_addr(input int rule, input int word);
    logic [RAW-1:0] r;
    logic [WAW-1:0] w;
    r = RAW'(rule);
    w = WAW'(word);
    return {r, w};
  endfunction

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  // Present one write and wait for it to be accepted; returns in the cycle after the accept edge.
  task automatic send(input logic [AW-1:0] addr, input logic [CFG_DW-1:0] data);
    int n;
    i_cfg_valid = 1'b1;
    i_cfg_addr  = addr;
    i_cfg_data  = data;
    n = 0;
    while (!o_cfg_ready && n < 50) begin
      cyc();
      n++;
    end
    if (!o_cfg_ready) check("accept_timeout", o_cfg_ready, 1);
    cyc();
    i_cfg_valid = 1'b0;
  endtask

  task automatic op_load(input int w, input logic [CFG_DW-1:0] d);
    send(mk_addr($urandom_range(0, RN - 1), w), d);
    m_words[w] = d;
    check("load_err", o_err, 0);
    check("load_wren", o_rule_wren, 0);
    check("load_ready", o_cfg_ready, 1);
    check("load_hold_rule", o_type_rule, m_rule);
  endtask

  task automatic op_commit(input int r, input logic [CFG_DW-1:0] d);
    logic [RN-1:0] exp_wren;
    send(mk_addr(r, CFG_WORD_COMMIT), d);
    m_rule   = model_commit(d[0]);
    exp_wren = '0;
    exp_wren[r] = 1'b1;
    check("commit_wren", o_rule_wren, exp_wren);
    check("commit_rule", o_type_rule, m_rule);
    check("commit_ready", o_cfg_ready, 0);
    check("commit_busy", o_busy, 1);
    cyc();
    check("commit_wren_end", o_rule_wren, 0);
    check("commit_ready_end", o_cfg_ready, 1);
    check("commit_busy_end", o_busy, 0);
    check("commit_rule_hold", o_type_rule, m_rule);
  endtask

  task automatic op_bad(input logic [AW-1:0] addr, input logic [CFG_DW-1:0] d);
    send(addr, d);
    check("bad_err", o_err, 1);
    check("bad_wren", o_rule_wren, 0);
    check("bad_rule", o_type_rule, m_rule);
    cyc();
    check("bad_err_end", o_err, 0);
    check("bad_wren_end", o_rule_wren, 0);
  endtask

  // Clear-all; optionally holds a shadow load pending on the bus for the whole sequence.
  task automatic op_clear(input bit pend, input int pw, input logic [CFG_DW-1:0] pd);
    logic [RN-1:0] exp_wren;
    send(mk_addr($urandom_range(0, (1 << RAW) - 1), CFG_WORD_CLEAR), $urandom());
    m_rule = '0;
    if (pend) begin
      i_cfg_valid = 1'b1;
      i_cfg_addr  = mk_addr(0, pw);
      i_cfg_data  = pd;
    end
    for (int k = 0; k < RN; k++) begin
      exp_wren = '0;
      exp_wren[k] = 1'b1;
      check("clear_wren", o_rule_wren, exp_wren);
      check("clear_rule", o_type_rule, 0);
      check("clear_busy", o_busy, 1);
      check("clear_ready", o_cfg_ready, 0);
      cyc();
    end
    check("clear_done_ready", o_cfg_ready, 1);
    check("clear_done_wren", o_rule_wren, 0);
    check("clear_done_busy", o_busy, 0);
    if (pend) begin
      cyc();
      i_cfg_valid = 1'b0;
      m_words[pw] = pd;
      check("pend_err", o_err, 0);
      check("pend_wren", o_rule_wren, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int w = 0; w < RULE_WORDS; w++) m_words[w] = '0;
    m_rule = '0;
    #12;
    check("rst_wren", o_rule_wren, 0);
    check("rst_rule", o_type_rule, 0);
    check("rst_busy", o_busy, 0);
    check("rst_err", o_err, 0);
    check("rst_ready", o_cfg_ready, 1);
    i_rst_n = 1'b1;
    cyc();

    // Known pattern, commit to rule 2, re-commit same shadow to rule 0 with valid cleared.
    op_load(0, 32'hA5A5_1234);
    op_load(1, 32'h5A5A_CDEF);
    op_load(2, 32'hFFFF_FFFF);
    op_commit(2, 32'h1);
    op_commit(0, 32'h0);

    // Clear-all with a held pending write, which must land afterwards.
    op_clear(1'b1, 1, 32'h0BAD_F00D);
    op_commit(RN - 1, 32'h1);

    // Rejected writes leave the shadow untouched.
    if (RN < (1 << RAW)) op_bad(mk_addr(RN, CFG_WORD_COMMIT), 32'h1);
    op_bad(mk_addr(0, RULE_WORDS), 32'hDEAD_BEEF);
    op_commit(3, 32'h1);

    // Back-to-back loads with valid held high.
    i_cfg_valid = 1'b1;
    for (int w = 0; w < RULE_WORDS; w++) begin
      i_cfg_addr = mk_addr(0, w);
      i_cfg_data = 32'h1111_1111 * (w + 3);
      check("b2b_ready", o_cfg_ready, 1);
      cyc();
      m_words[w] = 32'h1111_1111 * (w + 3);
      check("b2b_err", o_err, 0);
    end
    i_cfg_valid = 1'b0;
    op_commit(1, 32'h1);

    // Random traffic.
    for (int i = 0; i < 80; i++) begin
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 4) begin
        op_load($urandom_range(0, RULE_WORDS - 1), $urandom());
      end else if (sel < 7) begin
        op_commit($urandom_range(0, RN - 1), $urandom());
      end else if (sel < 9) begin
        if (sel == 7 && RN < (1 << RAW))
          op_bad(mk_addr($urandom_range(RN, (1 << RAW) - 1), CFG_WORD_COMMIT), $urandom());
        else
          op_bad(mk_addr($urandom_range(0, RN - 1), $urandom_range(RULE_WORDS, CFG_WORD_CLEAR - 1)),
                 $urandom());
      end else begin
        op_clear(1'($urandom_range(0, 1)), $urandom_range(0, RULE_WORDS - 1), $urandom());
      end
    end

    // Reset in the middle of a clear aborts it immediately.
    send(mk_addr(0, CFG_WORD_CLEAR), 32'h0);
    cyc();
    cyc();
    #2;
    i_rst_n = 1'b0;
    #1;
    check("rst_mid_wren", o_rule_wren, 0);
    check("rst_mid_ready", o_cfg_ready, 1);
    check("rst_mid_busy", o_busy, 0);
    cyc();
    i_rst_n = 1'b1;
    for (int w = 0; w < RULE_WORDS; w++) m_words[w] = '0;
    m_rule = '0;
    cyc();
    check("rst_rel_ready", o_cfg_ready, 1);
    check("rst_rel_wren", o_rule_wren, 0);
    op_commit(1, 32'h1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
